uart_packet_rx: RTL and testbench

Parametrised packet receiver between the UART byte receiver and the control unit. It frames incoming bytes into one packet each: start, mode, optional label, payload, checksum, stop. A packet commits only when its checksum and stop byte are both good, and the committed payload, mode and label are then held stable for the control unit. Malformed, corrupted or stalled packets are dropped and reported with an error code, so a bad packet never corrupts the held image.

---
 rtl/uart_packet_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_packet_rx.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_rx.sv
// Packet receiver that sits after the UART byte receiver.
// It frames bytes into packets: start, mode, optional label, payload, checksum, stop.
// The payload, label and train flag are only updated when a whole packet checks out.
// Bad, corrupted or stalled packets are dropped and reported through err_code.
module uart_packet_rx #(
    parameter int unsigned IMG_BYTES   = 784,
    parameter logic [7:0]  START_BYTE  = 8'hff,
    parameter logic [7:0]  STOP_BYTE   = 8'hff,
    parameter logic [7:0]  TRAIN_BYTE  = 8'hf0,
    parameter logic [7:0]  TEST_BYTE   = 8'h0f,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_rdy,
    input  logic [7:0]             uart_byte,
    output logic [IMG_BYTES*8-1:0] image,
    output logic [7:0]             label,
    output logic                   train,
    output logic                   pkt_valid,
    output logic                   pkt_err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int unsigned CntW  = $clog2(IMG_BYTES + 1);
    localparam int unsigned IdleW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CntW-1:0]  LastIdx = CntW'(IMG_BYTES - 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        StIdle,
        StMode,
        StLabel,
        StData,
        StCsum,
        StStop
    } state_e;

    state_e                 state_q;
    logic [IMG_BYTES*8-1:0] work_q;
    logic [IMG_BYTES*8-1:0] work_shift;
    logic [7:0]             csum_q;
    logic [7:0]             lbl_q;
    logic                   train_q;
    logic [CntW-1:0]        cnt_q;
    logic [IdleW-1:0]       idle_q;
    logic                   timeout;

    // A strobe in the cycle the counter hits its limit wins over the timeout.
    assign timeout = (TIMEOUT_CYC != 0) && (state_q != StIdle) && !data_rdy &&
                     (idle_q == IdleMax);

    assign busy = (state_q != StIdle);

    // Working buffer shifted left by one byte; first payload byte ends up at the MSB.
    always_comb begin
        work_shift      = '0;
        work_shift[7:0] = uart_byte;
        for (int i = 1; i < int'(IMG_BYTES); i++) begin
            work_shift[i*8 +: 8] = work_q[(i-1)*8 +: 8];
        end
    end

    // Packet framing FSM with registered outputs, idle counter and commit logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            work_q    <= '0;
            csum_q    <= '0;
            lbl_q     <= '0;
            train_q   <= 1'b0;
            cnt_q     <= '0;
            idle_q    <= '0;
            image     <= '0;
            label     <= '0;
            train     <= 1'b0;
            pkt_valid <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= '0;
        end else begin
            pkt_valid <= 1'b0;
            pkt_err   <= 1'b0;

            if (state_q == StIdle || data_rdy) begin
                idle_q <= '0;
            end else if (TIMEOUT_CYC != 0) begin
                idle_q <= idle_q + 1'b1;
            end

            if (timeout) begin
                state_q  <= StIdle;
                pkt_err  <= 1'b1;
                err_code <= 2'd3;
                idle_q   <= '0;
            end else if (data_rdy) begin
                case (state_q)
                    StIdle: begin
                        if (uart_byte == START_BYTE) begin
                            state_q <= StMode;
                        end
                    end
                    StMode: begin
                        if (uart_byte == TRAIN_BYTE) begin
                            train_q <= 1'b1;
                            state_q <= StLabel;
                        end else if (uart_byte == TEST_BYTE) begin
                            train_q <= 1'b0;
                            lbl_q   <= '0;
                            cnt_q   <= '0;
                            csum_q  <= '0;
                            state_q <= StData;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd0;
                            state_q  <= StIdle;
                        end
                    end
                    StLabel: begin
                        if (32'(uart_byte) < NUM_CLASSES) begin
                            lbl_q   <= uart_byte;
                            cnt_q   <= '0;
                            csum_q  <= '0;
                            state_q <= StData;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd0;
                            state_q  <= StIdle;
                        end
                    end
                    StData: begin
                        work_q <= work_shift;
                        csum_q <= csum_q ^ uart_byte;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == LastIdx) begin
                            state_q <= StCsum;
                        end
                    end
                    StCsum: begin
                        if (uart_byte == csum_q) begin
                            state_q <= StStop;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd1;
                            state_q  <= StIdle;
                        end
                    end
                    StStop: begin
                        if (uart_byte == STOP_BYTE) begin
                            image     <= work_q;
                            label     <= lbl_q;
                            train     <= train_q;
                            pkt_valid <= 1'b1;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd2;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Self-checking bench for uart_packet_rx: directed scenarios plus randomized packets
// checked against a list-based packet parser model.
module tb_uart_packet_rx;

    localparam int unsigned BigBytes = 784;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data_rdy = 1'b0;
    logic [7:0] uart_byte = 8'h00;

    logic [31:0] image;   logic [7:0] label;   logic train, pkt_valid, pkt_err, busy;
    logic [1:0] err_code;
    logic [31:0] image_z; logic [7:0] label_z; logic train_z, pkt_valid_z, pkt_err_z, busy_z;
    logic [1:0] err_code_z;
    logic [BigBytes*8-1:0] image_b; logic [7:0] label_b;
    logic train_b, pkt_valid_b, pkt_err_b, busy_b;
    logic [1:0] err_code_b;

    int checks = 0;
    int errors = 0;
    int nvalid = 0, nerr = 0, nerr_z = 0, nvalid_b = 0, nerr_b = 0;

    // Expected held outputs of the IMG_BYTES=4 instance
    logic [31:0] h_img = '0;
    logic [7:0]  h_lbl = '0;
    bit          h_trn = 1'b0;

    uart_packet_rx #(.IMG_BYTES(4), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst), .data_rdy(data_rdy), .uart_byte(uart_byte),
        .image(image), .label(label), .train(train), .pkt_valid(pkt_valid),
        .pkt_err(pkt_err), .err_code(err_code), .busy(busy));

    uart_packet_rx #(.IMG_BYTES(4), .TIMEOUT_CYC(0)) dut_z (
        .clk(clk), .rst(rst), .data_rdy(data_rdy), .uart_byte(uart_byte),
        .image(image_z), .label(label_z), .train(train_z), .pkt_valid(pkt_valid_z),
        .pkt_err(pkt_err_z), .err_code(err_code_z), .busy(busy_z));

    uart_packet_rx #(.IMG_BYTES(BigBytes), .TIMEOUT_CYC(20)) dut_b (
        .clk(clk), .rst(rst), .data_rdy(data_rdy), .uart_byte(uart_byte),
        .image(image_b), .label(label_b), .train(train_b), .pkt_valid(pkt_valid_b),
        .pkt_err(pkt_err_b), .err_code(err_code_b), .busy(busy_b));

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (pkt_valid)   nvalid++;
        if (pkt_err)     nerr++;
        if (pkt_err_z)   nerr_z++;
        if (pkt_valid_b) nvalid_b++;
        if (pkt_err_b)   nerr_b++;
    end

    task automatic strobe(input logic [7:0] b);
        data_rdy  = 1'b1;
        uart_byte = b;
        @(negedge clk);
        data_rdy  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] p[$], input int last, input int gap);
        for (int i = 0; i <= last; i++) begin
            strobe(p[i]);
            if (i < last && gap > 0) idle(int'($urandom_range(0, gap)));
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        h_img = '0;
        h_lbl = '0;
        h_trn = 1'b0;
    endtask

    // Reference parser: walks the byte list by the packet rules and reports where the
    // packet ends, whether it commits, the error cause and the fields it carries.
    function automatic void model(input logic [7:0] p[$], output int last, output bit ok,
                                  output logic [1:0] code, output logic [31:0] img,
                                  output logic [7:0] lbl, output bit trn);
        int i;
        logic [7:0] x;
        ok = 1'b0; code = 2'd0; img = '0; lbl = '0; trn = 1'b0; x = '0; last = 1; i = 2;
        if (p[1] == 8'hf0) begin
            trn  = 1'b1;
            last = 2;
            if (p[2] >= 8'd10) return;
            lbl = p[2];
            i   = 3;
        end else if (p[1] != 8'h0f) begin
            return;
        end
        for (int k = 0; k < 4; k++) begin
            img = {img[23:0], p[i+k]};
            x   = x ^ p[i+k];
        end
        last = i + 4;
        if (p[last] != x) begin
            code = 2'd1;
            return;
        end
        last++;
        if (p[last] != 8'hff) begin
            code = 2'd2;
            return;
        end
        ok = 1'b1;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        checks++; if (image !== 32'h0) begin errors++; $display("FAIL rst_image got %h want 0", image); end
        checks++; if (label !== 8'h0) begin errors++; $display("FAIL rst_label got %h want 0", label); end
        checks++; if (train !== 1'b0) begin errors++; $display("FAIL rst_train got %b want 0", train); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", pkt_valid); end
        checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", pkt_err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_code got %0d want 0", err_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (image_b !== '0) begin errors++; $display("FAIL rst_image_b got nonzero want 0"); end
    endtask

    task automatic test_test_packet;
        logic [7:0] p[$];
        do_reset;
        p = '{8'hff, 8'h0f, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'hff};
        send(p, 7, 0);
        checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b want 1", pkt_valid); end
        checks++; if (image !== 32'h01020304) begin errors++; $display("FAIL t1_image got %h want 01020304", image); end
        checks++; if (train !== 1'b0) begin errors++; $display("FAIL t1_train got %b want 0", train); end
        checks++; if (label !== 8'h00) begin errors++; $display("FAIL t1_label got %h want 00", label); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy got %b want 0", busy); end
        idle(1);
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL t1_pulse got %b want 0", pkt_valid); end
    endtask

    task automatic test_train_label;
        logic [7:0] p[$];
        p = '{8'hff, 8'hf0, 8'h07, 8'ha0, 8'hb0, 8'hc0, 8'hd0, 8'h00, 8'hff};
        send(p, 8, 2);
        checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL t2_valid got %b want 1", pkt_valid); end
        checks++; if (image !== 32'ha0b0c0d0) begin errors++; $display("FAIL t2_image got %h want a0b0c0d0", image); end
        checks++; if (label !== 8'd7) begin errors++; $display("FAIL t2_label got %h want 07", label); end
        checks++; if (train !== 1'b1) begin errors++; $display("FAIL t2_train got %b want 1", train); end
        p = '{8'hff, 8'hf0, 8'h0a};
        send(p, 2, 0);
        checks++; if (pkt_err !== 1'b1 || err_code !== 2'd0) begin
            errors++; $display("FAIL t2_badlabel got err=%b code=%0d want err=1 code=0", pkt_err, err_code); end
        checks++; if (image !== 32'ha0b0c0d0 || label !== 8'd7) begin
            errors++; $display("FAIL t2_held got %h/%h want a0b0c0d0/07", image, label); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_busy got %b want 0", busy); end
    endtask

    task automatic test_csum_stop;
        logic [7:0] p[$];
        int v0;
        v0 = nvalid;
        p = '{8'hff, 8'h0f, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send(p, 6, 0);
        checks++; if (pkt_err !== 1'b1 || err_code !== 2'd1) begin
            errors++; $display("FAIL t3_csum got err=%b code=%0d want err=1 code=1", pkt_err, err_code); end
        checks++; if (image !== 32'ha0b0c0d0 || train !== 1'b1) begin
            errors++; $display("FAIL t3_held got %h/%b want a0b0c0d0/1", image, train); end
        idle(1);
        checks++; if (pkt_err !== 1'b0 || err_code !== 2'd1) begin
            errors++; $display("FAIL t3_codehold got err=%b code=%0d want err=0 code=1", pkt_err, err_code); end
        p = '{8'hff, 8'h0f, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00};
        send(p, 7, 0);
        checks++; if (pkt_err !== 1'b1 || err_code !== 2'd2) begin
            errors++; $display("FAIL t3_stop got err=%b code=%0d want err=1 code=2", pkt_err, err_code); end
        #1;
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL t3_novalid got %0d want %0d", nvalid, v0); end
    endtask

    task automatic test_timeout;
        logic [7:0] p[$];
        int e0;
        do_reset;
        p = '{8'hff, 8'h0f, 8'h01};
        send(p, 2, 0);
        idle(20);
        checks++; if (pkt_err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_early got err=%b busy=%b want err=0 busy=1", pkt_err, busy); end
        idle(1);
        checks++; if (pkt_err !== 1'b1 || err_code !== 2'd3) begin
            errors++; $display("FAIL to_fire got err=%b code=%0d want err=1 code=3", pkt_err, err_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b want 0", busy); end
        #1;
        e0 = nerr;
        send(p, 2, 0);
        idle(20);
        strobe(8'h02);
        checks++; if (pkt_err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_bytewins got err=%b busy=%b want err=0 busy=1", pkt_err, busy); end
        idle(20);
        p = '{8'h03, 8'h04, 8'h04, 8'hff};
        send(p, 3, 0);
        checks++; if (pkt_valid !== 1'b1 || image !== 32'h01020304) begin
            errors++; $display("FAIL to_commit got v=%b img=%h want v=1 img=01020304", pkt_valid, image); end
        #1;
        checks++; if (nerr !== e0) begin errors++; $display("FAIL to_noerr got %0d want %0d", nerr, e0); end
    endtask

    task automatic test_timeout_disabled;
        logic [7:0] p[$];
        int ez, e0;
        do_reset;
        #1;
        ez = nerr_z;
        e0 = nerr;
        p = '{8'hff, 8'h0f, 8'h01};
        send(p, 2, 0);
        idle(1000);
        #1;
        checks++; if (nerr_z !== ez || busy_z !== 1'b1) begin
            errors++; $display("FAIL tz_gap got errs=%0d busy=%b want errs=%0d busy=1", nerr_z, busy_z, ez); end
        checks++; if (nerr !== e0 + 1) begin errors++; $display("FAIL tz_ref got %0d want %0d", nerr, e0 + 1); end
        p = '{8'h02, 8'h03, 8'h04, 8'h04, 8'hff};
        send(p, 4, 0);
        checks++; if (pkt_valid_z !== 1'b1 || image_z !== 32'h01020304) begin
            errors++; $display("FAIL tz_commit got v=%b img=%h want v=1 img=01020304", pkt_valid_z, image_z); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] p[$];
        int e0;
        do_reset;
        p = '{8'hff, 8'h0f, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0c, 8'hff};
        send(p, 7, 0);
        checks++; if (image !== 32'h05060708) begin errors++; $display("FAIL mr_pre got %h want 05060708", image); end
        #1;
        e0 = nerr;
        p = '{8'hff, 8'h0f, 8'h01, 8'h02};
        send(p, 3, 0);
        do_reset;
        checks++; if (image !== 32'h0 || label !== 8'h0 || train !== 1'b0) begin
            errors++; $display("FAIL mr_held got %h/%h/%b want 0/0/0", image, label, train); end
        checks++; if (busy !== 1'b0 || pkt_valid !== 1'b0 || pkt_err !== 1'b0 || err_code !== 2'd0) begin
            errors++; $display("FAIL mr_ctl got b=%b v=%b e=%b c=%0d want all 0", busy, pkt_valid, pkt_err, err_code); end
        p = '{8'h00, 8'h12};
        send(p, 1, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_ignore got busy=%b want 0", busy); end
        #1;
        checks++; if (nerr !== e0) begin errors++; $display("FAIL mr_noerr got %0d want %0d", nerr, e0); end
        p = '{8'hff, 8'h0f, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'hff};
        send(p, 7, 0);
        checks++; if (pkt_valid !== 1'b1 || image !== 32'h01020304) begin
            errors++; $display("FAIL mr_commit got v=%b img=%h want v=1 img=01020304", pkt_valid, image); end
        h_img = 32'h01020304;
    endtask

    task automatic test_random;
        logic [7:0] p[$];
        logic [7:0] m, b, x;
        logic [1:0] code;
        logic [31:0] img;
        logic [7:0] lbl;
        bit ok, trn;
        int kind, last, v0, e0;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 7));
            p.delete();
            p.push_back(8'hff);
            if (kind == 0) begin
                do m = 8'($urandom); while (m == 8'hf0 || m == 8'h0f);
                p.push_back(m);
            end else if (kind == 1 || $urandom_range(0, 1) == 1) begin
                p.push_back(8'hf0);
                p.push_back(kind == 1 ? 8'($urandom_range(10, 255)) : 8'($urandom_range(0, 9)));
            end else begin
                p.push_back(8'h0f);
            end
            x = '0;
            for (int k = 0; k < 4; k++) begin
                b = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom);
                p.push_back(b);
                x = x ^ b;
            end
            if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
            p.push_back(x);
            p.push_back(kind == 3 ? 8'($urandom_range(0, 254)) : 8'hff);
            model(p, last, ok, code, img, lbl, trn);
            #1;
            v0 = nvalid;
            e0 = nerr;
            if ($urandom_range(0, 2) == 0) strobe(8'($urandom_range(0, 254)));
            idle(int'($urandom_range(1, 3)));
            send(p, last, 3);
            if (ok) begin
                h_img = img; h_lbl = lbl; h_trn = trn;
                checks++; if (pkt_valid !== 1'b1 || pkt_err !== 1'b0) begin
                    errors++; $display("FAIL rnd%0d_commit got v=%b e=%b want v=1 e=0", n, pkt_valid, pkt_err); end
            end else begin
                checks++; if (pkt_err !== 1'b1 || err_code !== code || pkt_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd%0d_drop got e=%b c=%0d v=%b want e=1 c=%0d v=0",
                                       n, pkt_err, err_code, pkt_valid, code); end
            end
            checks++; if (image !== h_img || label !== h_lbl || train !== h_trn) begin
                errors++; $display("FAIL rnd%0d_held got %h/%h/%b want %h/%h/%b",
                                   n, image, label, train, h_img, h_lbl, h_trn); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy got %b want 0", n, busy); end
            #1;
            checks++; if (nvalid - v0 !== int'(ok) || nerr - e0 !== int'(!ok)) begin
                errors++; $display("FAIL rnd%0d_pulses got v=%0d e=%0d want v=%0d e=%0d",
                                   n, nvalid - v0, nerr - e0, int'(ok), int'(!ok)); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] q0[$], q1[$];
        logic [BigBytes*8-1:0] e0, e1;
        logic [7:0] b, x;
        int v0, er0, bad;
        do_reset;
        for (int pk = 0; pk < 2; pk++) begin
            logic [7:0] q[$];
            logic [BigBytes*8-1:0] e;
            q.push_back(8'hff);
            q.push_back(8'h0f);
            x = '0;
            e = '0;
            for (int k = 0; k < int'(BigBytes); k++) begin
                b = ($urandom_range(0, 7) == 0) ? 8'hff : 8'($urandom);
                q.push_back(b);
                x = x ^ b;
                e[(int'(BigBytes) - 1 - k)*8 +: 8] = b;
            end
            q.push_back(x);
            q.push_back(8'hff);
            if (pk == 0) begin q0 = q; e0 = e; end else begin q1 = q; e1 = e; end
        end
        #1;
        v0  = nvalid_b;
        er0 = nerr_b;
        send(q0, q0.size() - 1, 0);
        checks++; if (pkt_valid_b !== 1'b1) begin errors++; $display("FAIL b2b_valid0 got %b want 1", pkt_valid_b); end
        checks++; if (image_b !== e0) begin
            errors++; bad = -1;
            for (int k = int'(BigBytes) - 1; k >= 0; k--)
                if (image_b[(int'(BigBytes) - 1 - k)*8 +: 8] !== e0[(int'(BigBytes) - 1 - k)*8 +: 8]) bad = k;
            $display("FAIL b2b_image0 first bad byte %0d got %h want %h", bad,
                     image_b[(int'(BigBytes) - 1 - bad)*8 +: 8], e0[(int'(BigBytes) - 1 - bad)*8 +: 8]);
        end
        send(q1, q1.size() - 1, 0);
        checks++; if (pkt_valid_b !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b want 1", pkt_valid_b); end
        checks++; if (image_b !== e1) begin
            errors++; bad = -1;
            for (int k = int'(BigBytes) - 1; k >= 0; k--)
                if (image_b[(int'(BigBytes) - 1 - k)*8 +: 8] !== e1[(int'(BigBytes) - 1 - k)*8 +: 8]) bad = k;
            $display("FAIL b2b_image1 first bad byte %0d got %h want %h", bad,
                     image_b[(int'(BigBytes) - 1 - bad)*8 +: 8], e1[(int'(BigBytes) - 1 - bad)*8 +: 8]);
        end
        checks++; if (busy_b !== 1'b0 || train_b !== 1'b0) begin
            errors++; $display("FAIL b2b_state got busy=%b train=%b want 0/0", busy_b, train_b); end
        #1;
        checks++; if (nvalid_b - v0 !== 2 || nerr_b !== er0) begin
            errors++; $display("FAIL b2b_pulses got v=%0d e=%0d want v=2 e=0", nvalid_b - v0, nerr_b - er0); end
    endtask

    initial begin
        test_reset;
        test_test_packet;
        test_train_label;
        test_csum_stop;
        test_timeout;
        test_timeout_disabled;
        test_mid_reset;
        test_random;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
